sata_rx_descrambler: RTL

//  Receive-side link-layer front end; mirror of the transmit scrambler.

---
 rtl/sata_rx_descrambler_if.sv | 26 ++
 rtl/sata_rx_descrambler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sata_rx_descrambler_if.sv
// sata_rx_descrambler_if
//   PHY-side receive dwords in, classified/descrambled dwords out.
//   master: the PHY / upstream driver.  slave: the descrambler.
interface sata_rx_descrambler_if;
    logic [31:0] rx_data;
    logic        rx_charisk;
    logic        rx_valid;
    logic [31:0] out_data;
    logic        out_prim;
    logic        out_valid;
    logic        in_frame;
    logic        sof_p;
    logic        eof_p;
    logic        err_p;
    logic [15:0] err_cnt;

    modport master (
        output rx_data, rx_charisk, rx_valid,
        input  out_data, out_prim, out_valid, in_frame, sof_p, eof_p, err_p, err_cnt
    );

    modport slave (
        input  rx_data, rx_charisk, rx_valid,
        output out_data, out_prim, out_valid, in_frame, sof_p, eof_p, err_p, err_cnt
    );
endinterface

// File: rtl/sata_rx_descrambler.sv
// sata_rx_descrambler
//   Receive link-layer front end.  Drops ALIGN, expands CONT into repeats of
//   the last primitive, tracks SOF..EOF framing and descrambles frame payload
//   with the SATA LFSR (x^16+x^15+x^13+x^4+1), context reloaded on every SOF.
//   All outputs are registered one cycle after the accepted input dword.
//   Optional feature macro: SATA_RX_ERR_CNT_EN adds a saturating 16-bit
//   protocol-error counter; without it err_cnt is tied to zero.
module sata_rx_descrambler #(
    parameter logic [15:0] SEED = 16'hF0F6
) (
    input  logic                 clk_75m,
    input  logic                 rst_n,
    sata_rx_descrambler_if.slave bus
);

    // Primitives that change behaviour.  HOLD, HOLDA, SYNC and all other K
    // dwords share the generic "other primitive" path.
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;
    localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]  state_q,        state_d;
    logic [15:0] ctx_q,          ctx_d;
    logic        cont_act_q,     cont_act_d;
    logic [31:0] last_prim_q,    last_prim_d;
    logic        last_prim_ok_q, last_prim_ok_d;
    logic [31:0] out_data_q,     out_data_d;
    logic        out_prim_q,     out_prim_d;
    logic        out_valid_q,    out_valid_d;
    logic        sof_p_q,        sof_p_d;
    logic        eof_p_q,        eof_p_d;
    logic        err_p_q,        err_p_d;

    logic [31:0] ks;
    logic        is_align;
    logic        is_cont;
    logic        is_sof;
    logic        is_eof;

    assign is_align = bus.rx_charisk && (bus.rx_data == PRIM_ALIGN);
    assign is_cont  = bus.rx_charisk && (bus.rx_data == PRIM_CONT);
    assign is_sof   = bus.rx_charisk && (bus.rx_data == PRIM_SOF);
    assign is_eof   = bus.rx_charisk && (bus.rx_data == PRIM_EOF);

    // Keystream: the context holds the last 16 LFSR output bits (oldest in
    // bit 0); the next 32 bits follow from the recurrence
    // s[n] = s[n-1] ^ s[n-3] ^ s[n-12] ^ s[n-16], so the new context is ks[31:16].
    always_comb begin : keystream
        logic [47:0] seq;
        seq       = '0;
        seq[15:0] = ctx_q;
        for (int i = 16; i < 48; i++) begin
            seq[i] = seq[i-1] ^ seq[i-3] ^ seq[i-12] ^ seq[i-16];
        end
        ks = seq[47:16];
    end

    // Classify the incoming dword and compute next framing, CONT and LFSR state.
    always_comb begin
        // NOTE: every _d gets a hold/idle default first so no path can infer a latch.
        state_d        = state_q;
        ctx_d          = ctx_q;
        cont_act_d     = cont_act_q;
        last_prim_d    = last_prim_q;
        last_prim_ok_d = last_prim_ok_q;
        out_data_d     = out_data_q;
        out_prim_d     = out_prim_q;
        out_valid_d    = 1'b0;
        sof_p_d        = 1'b0;
        eof_p_d        = 1'b0;
        err_p_d        = 1'b0;

        if (bus.rx_valid) begin
            if (is_align) begin
                // ALIGN is invisible: nothing emitted, nothing changes.
            end else if (is_cont) begin
                if (last_prim_ok_q) begin
                    cont_act_d  = 1'b1;
                    out_data_d  = last_prim_q;
                    out_prim_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    err_p_d = 1'b1;
                end
            end else if (bus.rx_charisk) begin
                // Any real primitive ends a CONT run and becomes the repeat source.
                last_prim_d    = bus.rx_data;
                last_prim_ok_d = 1'b1;
                cont_act_d     = 1'b0;
                out_data_d     = bus.rx_data;
                out_prim_d     = 1'b1;
                out_valid_d    = 1'b1;
                if (is_sof) begin
                    err_p_d = (state_q == ST_FRAME);
                    state_d = ST_FRAME;
                    ctx_d   = SEED;
                    sof_p_d = 1'b1;
                end else if (is_eof && (state_q == ST_FRAME)) begin
                    state_d = ST_IDLE;
                    eof_p_d = 1'b1;
                end
            end else if (cont_act_q) begin
                // Junk filler inside a CONT run stands for the repeated primitive.
                out_data_d  = last_prim_q;
                out_prim_d  = 1'b1;
                out_valid_d = 1'b1;
            end else if (state_q == ST_FRAME) begin
                out_data_d  = bus.rx_data ^ ks;
                out_prim_d  = 1'b0;
                out_valid_d = 1'b1;
                ctx_d       = ks[31:16];
            end else begin
                err_p_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_75m or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ctx_q          <= SEED;
            cont_act_q     <= 1'b0;
            last_prim_q    <= '0;
            last_prim_ok_q <= 1'b0;
            out_data_q     <= '0;
            out_prim_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            sof_p_q        <= 1'b0;
            eof_p_q        <= 1'b0;
            err_p_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q        <= state_d;
            ctx_q          <= ctx_d;
            cont_act_q     <= cont_act_d;
            last_prim_q    <= last_prim_d;
            last_prim_ok_q <= last_prim_ok_d;
            out_data_q     <= out_data_d;
            out_prim_q     <= out_prim_d;
            out_valid_q    <= out_valid_d;
            sof_p_q        <= sof_p_d;
            eof_p_q        <= eof_p_d;
            err_p_q        <= err_p_d;
        end
    end

`ifdef SATA_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating count of protocol errors, advanced alongside err_p.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_p_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk_75m or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 16'h0000;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_prim  = out_prim_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_frame  = (state_q == ST_FRAME);
    assign bus.sof_p     = sof_p_q;
    assign bus.eof_p     = eof_p_q;
    assign bus.err_p     = err_p_q;

endmodule
